// File: rtl/mux_pkg.sv
// mux_pkg: shared arbitration mode type and select-width helper
package mux_pkg;
  typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_t;
  function automatic int sel_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin / fixed-priority request arbiter owning the rotation pointer
module rr_arbiter import mux_pkg::*; #(
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  arb_mode_t         mode,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx
);
  logic [SEL_W-1:0] r_ptr;
  logic             w_found;
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = (mode == ARB_FIXED) ? k : int'(r_ptr) + k;
      j = (j >= NUM_IN) ? j - NUM_IN : j;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        grant_idx = SEL_W'(j);
      end
    end
    grant_onehot = w_found ? NUM_IN'(1) << grant_idx : '0;
  end
  // wrap explicitly so a non-power-of-two pointer never leaves 0..NUM_IN-1
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (advance && w_found && mode == ARB_RR)
      r_ptr <= (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N:1 arbitrating multiplexer with a registered valid/ready output stage
module arb_mux import mux_pkg::*; #(
  parameter int MUX_SIZE = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_IN*MUX_SIZE-1:0] IN_DATA,
  input  logic [NUM_IN-1:0]          IN_VALID,
  output logic [NUM_IN-1:0]          IN_READY,
  input  logic                       PRIO_MODE,
  output logic [MUX_SIZE-1:0]        OUT,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [SEL_W-1:0]           GRANT
);
  logic [MUX_SIZE-1:0] r_out;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_grant;
  logic                w_load_en;
  logic                w_advance;
  logic [NUM_IN-1:0]   w_onehot;
  logic [SEL_W-1:0]    w_idx;
  assign w_load_en = !r_out_valid || OUT_READY;
  assign w_advance = w_load_en && !RST;
  assign IN_READY  = w_advance ? w_onehot : '0;
  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;
  assign GRANT     = r_grant;
  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .clk(CLK),
    .rst(RST),
    .req(IN_VALID),
    .mode(arb_mode_t'(PRIO_MODE)),
    .advance(w_advance),
    .grant_onehot(w_onehot),
    .grant_idx(w_idx)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out <= '0;
      r_out_valid <= 1'b0;
      r_grant <= '0;
    end else if (w_load_en) begin
      r_out_valid <= |w_onehot;
      if (|w_onehot) begin
        r_out <= IN_DATA[w_idx*MUX_SIZE +: MUX_SIZE];
        r_grant <= w_idx;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: randomized and directed checks of arb_mux against a behavioural model
module tb_arb_mux;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data = '0;
  logic [3:0]   valid = '0;
  logic [3:0]   ready;
  logic         mode = 1'b0;
  logic [31:0]  out;
  logic         ov;
  logic         oready = 1'b1;
  logic [1:0]   grant;
  logic [95:0]  data3 = '0;
  logic [2:0]   valid3 = '0;
  logic [2:0]   ready3;
  logic [31:0]  out3;
  logic         ov3;
  logic         oready3 = 1'b1;
  logic [1:0]   grant3;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_out;
  logic        m_ov;
  int          m_grant, m_ptr;

  arb_mux #(.MUX_SIZE(32), .NUM_IN(4)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(data), .IN_VALID(valid), .IN_READY(ready),
    .PRIO_MODE(mode), .OUT(out), .OUT_VALID(ov), .OUT_READY(oready), .GRANT(grant)
  );
  arb_mux #(.MUX_SIZE(32), .NUM_IN(3)) dut3 (
    .CLK(clk), .RST(rst), .IN_DATA(data3), .IN_VALID(valid3), .IN_READY(ready3),
    .PRIO_MODE(mode), .OUT(out3), .OUT_VALID(ov3), .OUT_READY(oready3), .GRANT(grant3)
  );

  always #5 clk = ~clk;

  // winner is the valid channel at the smallest rotational distance from the pointer
  function automatic int pick();
    int best = -1;
    int bd = 99;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = mode ? i : (i - m_ptr + 4) % 4;
      if (valid[i] && d < bd) begin
        bd = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = pick();
    if (rst || (m_ov && !oready) || g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  task automatic tick();
    int g;
    @(posedge clk);
    g = pick();
    if (rst) begin
      m_out = '0; m_ov = 1'b0; m_grant = 0; m_ptr = 0;
    end else if (!m_ov || oready) begin
      if (g >= 0) begin
        m_out = data[g*32 +: 32];
        m_grant = g;
        m_ov = 1'b1;
        if (!mode) m_ptr = (g + 1) % 4;
      end else m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'hA0 + i;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 4'hF; valid3 = 3'h7; set_abc();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", ready); end
      checks++; if (ready3 !== 3'b0) begin errors++; $display("FAIL reset_ready3 got=%b exp=000", ready3); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", ov); end
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", out); end
      checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant); end
    end
    valid3 = '0;
    rst = 1'b0;
  endtask

  task automatic test_rr_sequence();
    mode = 1'b0; valid = 4'hF; oready = 1'b1; set_abc();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, ready, 4'(1 << (k % 4))); end
      tick();
      checks++; if (out !== 32'hA0 + 32'(k % 4)) begin errors++; $display("FAIL rr_out k=%0d got=%h exp=%h", k, out, 32'hA0 + 32'(k % 4)); end
      checks++; if (grant !== 2'(k % 4) || ov !== 1'b1) begin errors++; $display("FAIL rr_grant k=%0d got=%0d/%b exp=%0d/1", k, grant, ov, k % 4); end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b1; valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready got=%b exp=0010", ready); end
      tick();
      checks++; if (grant !== 2'd1 || out !== 32'hA1) begin errors++; $display("FAIL fixed_ch1 got=%0d/%h exp=1/a1", grant, out); end
    end
    valid = 4'b1000; #1;
    checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL fixed_ready3 got=%b exp=1000", ready); end
    tick();
    checks++; if (grant !== 2'd3 || out !== 32'hA3) begin errors++; $display("FAIL fixed_ch3 got=%0d/%h exp=3/a3", grant, out); end
    mode = 1'b0; valid = 4'hF; #1;
    checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL fixed_ptr_kept got=%b exp=0010", ready); end
    tick();
    checks++; if (grant !== 2'd1) begin errors++; $display("FAIL fixed_ptr_grant got=%0d exp=1", grant); end
  endtask

  task automatic test_backpressure();
    tick();
    checks++; if (out !== 32'hA2 || ov !== 1'b1) begin errors++; $display("FAIL bp_setup got=%h/%b exp=a2/1", out, ov); end
    oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid = 4'($urandom); data = {$urandom, $urandom, $urandom, $urandom}; #1;
      checks++; if (ready !== 4'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0000", ready); end
      tick();
      checks++; if (out !== 32'hA2 || grant !== 2'd2 || ov !== 1'b1) begin errors++; $display("FAIL bp_hold got=%h/%0d/%b exp=a2/2/1", out, grant, ov); end
    end
    set_abc(); valid = 4'hF; oready = 1'b1; #1;
    checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got=%b exp=1000", ready); end
    tick();
    checks++; if (out !== 32'hA3 || grant !== 2'd3) begin errors++; $display("FAIL bp_release got=%h/%0d exp=a3/3", out, grant); end
  endtask

  task automatic test_nonpow2();
    int exp_g[5] = '{2, 0, 1, 2, 0};
    mode = 1'b0; oready3 = 1'b1;
    for (int i = 0; i < 3; i++) data3[i*32 +: 32] = 32'hC0 + i;
    valid3 = 3'b100;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (ready3 !== 3'(1 << exp_g[k])) begin errors++; $display("FAIL np2_ready k=%0d got=%b exp=%b", k, ready3, 3'(1 << exp_g[k])); end
      tick();
      checks++; if (grant3 !== 2'(exp_g[k]) || out3 !== 32'hC0 + 32'(exp_g[k])) begin errors++; $display("FAIL np2_grant k=%0d got=%0d/%h exp=%0d", k, grant3, out3, exp_g[k]); end
      valid3 = 3'b111;
    end
    valid3 = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      valid = 4'($urandom);
      mode = ($urandom_range(0, 3) == 0);
      oready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) data[i*32 +: 32] = $urandom;
      #1;
      checks++; if (ready !== exp_ready()) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ready, exp_ready()); end
      tick();
      checks++; if (ov !== m_ov) begin errors++; $display("FAIL rand_ov c=%0d got=%b exp=%b", c, ov, m_ov); end
      checks++; if (out !== m_out || grant !== 2'(m_grant)) begin errors++; $display("FAIL rand_out c=%0d got=%h/%0d exp=%h/%0d", c, out, grant, m_out, m_grant); end
    end
  endtask

  task automatic test_midreset();
    set_abc(); valid = 4'hF; oready = 1'b1; mode = 1'b0;
    tick();
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL mr_setup got=%b exp=1", ov); end
    rst = 1'b1; #1;
    checks++; if (ready !== 4'b0) begin errors++; $display("FAIL mr_ready got=%b exp=0000", ready); end
    tick();
    checks++; if (ov !== 1'b0 || out !== 32'h0 || grant !== 2'd0) begin errors++; $display("FAIL mr_clear got=%b/%h/%0d exp=0/0/0", ov, out, grant); end
    rst = 1'b0; valid = 4'b1100; #1;
    checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL mr_first_ready got=%b exp=0100", ready); end
    tick();
    checks++; if (grant !== 2'd2 || out !== 32'hA2 || ov !== 1'b1) begin errors++; $display("FAIL mr_first got=%0d/%h/%b exp=2/a2/1", grant, out, ov); end
  endtask

  initial begin
    m_out = '0; m_ov = 1'b0; m_grant = 0; m_ptr = 0;
    test_reset();
    test_rr_sequence();
    test_fixed();
    test_backpressure();
    test_nonpow2();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
